// File: rtl/seq_shift_add_mult.sv
// rtl/seq_shift_add_mult.sv - multi-cycle shift-and-add multiplier, one multiplier bit per clock
module seq_shift_add_mult #(
  parameter int A_W    = 8,
  parameter int B_W    = 8,
  parameter int SGN_EN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_W+B_W-1:0] product,
  output logic               busy
);

  localparam int P  = A_W + B_W;
  localparam int CW = $clog2(B_W);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [P-1:0]   mcand_q, mcand_d;
  logic [B_W-1:0] mplier_q, mplier_d;
  logic           neg_q, neg_d;
  logic [P-1:0]   acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [P-1:0]   product_q, product_d;
  logic           out_valid_q, out_valid_d;

  logic           sgn;
  logic           accept;
  logic           last_iter;
  logic [A_W-1:0] mag_a;
  logic [B_W-1:0] mag_b;
  logic [P-1:0]   acc_sum;

  // Negating the most negative value wraps back to 2^(W-1), which is exactly its magnitude.
  assign sgn       = signed_mode && (SGN_EN != 0);
  assign mag_a     = (sgn && a[A_W-1]) ? -a : a;
  assign mag_b     = (sgn && b[B_W-1]) ? -b : b;
  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign last_iter = (cnt_q == CW'(B_W - 1));
  assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    neg_d       = neg_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mcand_d  = {{B_W{1'b0}}, mag_a};
          mplier_d = mag_b;
          neg_d    = sgn && (a[A_W-1] ^ b[B_W-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        // The multiplicand shifts up while the multiplier shifts down, so bit i is always at [0].
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last_iter) begin
          product_d   = neg_q ? -acc_sum : acc_sum;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      neg_q       <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      neg_q       <= neg_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign product   = product_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != S_IDLE);

endmodule
